// File: rtl/seg_scan.sv
// seg_scan: multiplexed scanner for a common-anode 4-digit 7-segment display.
// Lights one digit per DIV-cycle slot, with BLANK leading dark cycles per slot
// to suppress ghosting, and pulses frame at the end of every full 4-digit scan.
// Build option: define SEG_SCAN_LATCH_EN to capture hexs into a shadow register
// at each frame start, so a frame never mixes old and new data.
module seg_scan #(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [27:0] hexs,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2 || BLANK < 0 || BLANK >= DIV) begin : g_bad_params
    $error("seg_scan: illegal parameters DIV=%0d BLANK=%0d", DIV, BLANK);
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;
  logic [27:0]   src;
  logic [6:0]    field;
  logic          lit;

  // Slot counter and digit index; disable parks the scan at digit 0, cycle 0.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

`ifdef SEG_SCAN_LATCH_EN
  logic [27:0] shadow_q, shadow_d;

  // Frame-start capture; feeding shadow_d forward lets a BLANK=0 digit 0 show
  // the freshly captured data in its very first lit cycle.
  always_comb begin
    shadow_d = shadow_q;
    if (cnt_q == '0 && idx_q == 2'd0) shadow_d = hexs;
    src = shadow_d;
  end

  // Shadow register for frame-coherent segment data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow_q <= '1;
    else       shadow_q <= shadow_d;
  end
`else
  // Live data path: segment data follows hexs with one cycle of latency.
  always_comb begin
    src = hexs;
  end
`endif

  // Output decode for the next cycle: blank/lit phase, anode select, segment field.
  always_comb begin
    field = src[27:21];
    case (idx_q)
      2'd0: field = src[27:21];
      2'd1: field = src[20:14];
      2'd2: field = src[13:7];
      2'd3: field = src[6:0];
      default: field = src[27:21];
    endcase
    lit     = enable && (int'(cnt_q) >= BLANK);
    an_d    = lit ? ~(4'b1000 >> idx_q) : '1;
    seg_d   = lit ? field : '1;
    frame_d = enable && (idx_q == 2'd3) && (cnt_q == LAST);
  end

  // State and registered outputs; reset darkens the display immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= '1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: two instances (DIV=8 with BLANK=2 and BLANK=0) share the
// inputs; a reference model pushes expected outputs each cycle and they are
// popped and compared one edge later, plus directed checks on key edges.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [27:0] hexs;
  logic [3:0]  an, an0;
  logic [6:0]  seg, seg0;
  logic        frame, frame0;

  always #5 clk = ~clk;

  seg_scan #(.DIV(8), .BLANK(2)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .hexs(hexs),
    .an(an), .seg(seg), .frame(frame)
  );

  seg_scan #(.DIV(8), .BLANK(0)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .hexs(hexs),
    .an(an0), .seg(seg0), .frame(frame0)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fr;
  } exp_t;

  exp_t        q2[$];
  exp_t        q0[$];
  int          m_cnt, m_idx;
  logic [27:0] m_shadow;
  int          edge_no;
  int          fr_cnt2, fr_cnt0, last_fr2, last_fr0;
  int          lit_cnt2, dark0, chg0, multi_lit;
  logic [3:0]  prev_an0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
  endtask

  function automatic exp_t predict(int blank, logic en, int idx, int cnt, logic [27:0] s);
    exp_t e;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.fr  = en && idx == 3 && cnt == 7;
    if (en && cnt >= blank) begin
      case (idx)
        0: begin e.an = 4'h7; e.seg = s[27:21]; end
        1: begin e.an = 4'hB; e.seg = s[20:14]; end
        2: begin e.an = 4'hD; e.seg = s[13:7];  end
        default: begin e.an = 4'hE; e.seg = s[6:0]; end
      endcase
    end
    return e;
  endfunction

  task automatic model_clear();
    q2.delete();
    q0.delete();
    m_cnt = 0; m_idx = 0; m_shadow = '1;
    edge_no = 0;
    fr_cnt2 = 0; fr_cnt0 = 0; last_fr2 = -1; last_fr0 = -1;
    lit_cnt2 = 0; dark0 = 0; chg0 = 0; multi_lit = 0;
    prev_an0 = 4'hF;
  endtask

  // One clock: push expectation from current inputs, advance model, compare after the edge.
  task automatic tick();
    logic [27:0] s;
    exp_t e;
`ifdef SEG_SCAN_LATCH_EN
    s = (m_cnt == 0 && m_idx == 0) ? hexs : m_shadow;
    m_shadow = s;
`else
    s = hexs;
`endif
    q2.push_back(predict(2, enable, m_idx, m_cnt, s));
    q0.push_back(predict(0, enable, m_idx, m_cnt, s));
    if (!enable) begin
      m_cnt = 0; m_idx = 0;
    end else if (m_cnt == 7) begin
      m_cnt = 0; m_idx = (m_idx + 1) % 4;
    end else begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
    edge_no++;
    e = q2.pop_front();
    check("an", an, e.an);
    check("seg", seg, e.seg);
    check("frame", frame, e.fr);
    e = q0.pop_front();
    check("an0", an0, e.an);
    check("seg0", seg0, e.seg);
    check("frame0", frame0, e.fr);
    if (frame)  begin fr_cnt2++; last_fr2 = edge_no; end
    if (frame0) begin fr_cnt0++; last_fr0 = edge_no; end
    if (an != 4'hF) lit_cnt2++;
    if (an0 == 4'hF) dark0++;
    if (an0 != prev_an0 && edge_no > 1) chg0++;
    prev_an0 = an0;
    if ($countones(~an) > 1 || $countones(~an0) > 1) multi_lit++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_frame", frame, 1'b0);
    check("rst_an0", an0, 4'hF);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    hexs   = 28'h0F3C1A5;
    #1;
    do_reset();

    // Normal scan for 40 cycles.
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (edge_no == 1)  check("t1_blank", an, 4'hF);
      if (edge_no == 3)  begin check("t1_an_d0", an, 4'h7); check("t1_seg_d0", seg, 7'h07); end
      if (edge_no == 11) begin check("t1_an_d1", an, 4'hB); check("t1_seg_d1", seg, 7'h4F); end
      if (edge_no == 19) begin check("t1_an_d2", an, 4'hD); check("t1_seg_d2", seg, 7'h03); end
      if (edge_no == 27) begin check("t1_an_d3", an, 4'hE); check("t1_seg_d3", seg, 7'h25); end
      if (edge_no == 32) check("t1_frame32", frame, 1'b1);
    end
    check("t1_frames", fr_cnt2, 1);
    check("t1_frame_edge", last_fr2, 32);
    check("t1_lit_cycles", lit_cnt2, 30);
    check("t1_onehot", multi_lit, 0);

    // Asynchronous reset while digit 2 is lit.
    do_reset();
    enable = 1'b1;
    repeat (20) tick();
    check("t2_d2_lit", an, 4'hD);
    #2 reset = 1'b1;
    #1;
    check("t2_async_an", an, 4'hF);
    check("t2_async_seg", seg, 7'h7F);
    #2 reset = 1'b0;
    model_clear();
    repeat (3) tick();
    check("t2_restart", an, 4'h7);

    // Enable dropped mid-digit 1 for 5 cycles.
    do_reset();
    enable = 1'b1;
    repeat (12) tick();
    enable = 1'b0;
    tick();
    check("t3_dark", an, 4'hF);
    repeat (4) tick();
    enable = 1'b1;
    repeat (3) tick();
    check("t3_d0_relit", an, 4'h7);
    check("t3_no_frame", fr_cnt2, 0);

    // hexs digit 1 changes mid-slot.
    do_reset();
    enable = 1'b1;
    repeat (12) tick();
    check("t4_old_d1", seg, 7'h4F);
    hexs[20:14] = 7'h40;
    tick();
`ifdef SEG_SCAN_LATCH_EN
    check("t4_held", seg, 7'h4F);
`else
    check("t4_live", seg, 7'h40);
`endif
    repeat (30) tick();
    check("t4_next_an", an, 4'hB);
    check("t4_next_seg", seg, 7'h40);
    hexs = 28'h0F3C1A5;

    // BLANK=0 instance over 64 cycles.
    do_reset();
    enable = 1'b1;
    tick();
    check("t5_first_lit", an0, 4'h7);
    repeat (63) tick();
    check("t5_no_dark", dark0, 0);
    check("t5_frames", fr_cnt0, 2);
    check("t5_frame_edge", last_fr0, 64);
    check("t5_changes", chg0, 7);
    check("t5_onehot", multi_lit, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
